// File: rtl/shreg_pkg.sv
// Shared constants for the shreg command sequencer: opcodes, shreg mode selects, FSM states.
// No logic; imported by shreg_carry_sel and shreg_ctrl.
// Optional feature macro: SHREG_ROTATE_EN (makes ROL/ROR/ASR legal).
package shreg_pkg;

  // Command opcodes
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHLS = 3'b011;
  localparam logic [2:0] OP_SHRS = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_ASR  = 3'b111;

  // shreg mode select encodings
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SHR  = 2'b01;  // msb <- carry_msb
  localparam logic [1:0] SR_SHL  = 2'b10;  // lsb <- carry_lsb
  localparam logic [1:0] SR_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shreg_carry_sel.sv
// Decodes the latched opcode into shreg mode select and carry inputs.
// Latency: purely combinational; carries follow sr_q/ser_in within the cycle.
// Backpressure: none; outputs are hold/zero whenever active is low.
// With SHREG_ROTATE_EN undefined the rotate/arith ops decode to hold and no feedback is built.
module shreg_carry_sel
  import shreg_pkg::*;
(
  input  logic [2:0] op,
  input  logic       active,
  input  logic [3:0] sr_q,
  input  logic       ser_in,
  output logic [1:0] mode,
  output logic       carry_msb,
  output logic       carry_lsb
);

  // Only some sr_q bits feed carries (none in the default build); fold the rest away.
  logic unused_sr_q;
  assign unused_sr_q = ^sr_q;

  // Mode and carry decode, idle/hold unless the FSM is in LOAD or SHIFT
  always_comb begin
    mode      = SR_HOLD;
    carry_msb = 1'b0;
    carry_lsb = 1'b0;
    if (active) begin
      case (op)
        OP_LOAD: mode = SR_LOAD;
        OP_SHL:  mode = SR_SHL;
        OP_SHR:  mode = SR_SHR;
        OP_SHLS: begin
          mode      = SR_SHL;
          carry_lsb = ser_in;
        end
        OP_SHRS: begin
          mode      = SR_SHR;
          carry_msb = ser_in;
        end
`ifdef SHREG_ROTATE_EN
        OP_ROL: begin
          mode      = SR_SHL;
          carry_lsb = sr_q[3];
        end
        OP_ROR: begin
          mode      = SR_SHR;
          carry_msb = sr_q[0];
        end
        OP_ASR: begin
          mode      = SR_SHR;
          carry_msb = sr_q[3];
        end
`endif
        default: mode = SR_HOLD;
      endcase
    end
  end

endmodule

// File: rtl/shreg_ctrl.sv
// Command sequencer driving one 4-bit universal shift register (shreg).
// Latency: LOAD done 1 cycle after accept, shift N done N cycles after, cnt=0/illegal done next cycle.
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is ignored, nothing is queued.
// Macro SHREG_ROTATE_EN enables ROL/ROR/ASR; otherwise 101-111 complete immediately with err.
module shreg_ctrl
  import shreg_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [3:0]       cmd_data,
  input  logic             ser_in,
  input  logic [3:0]       sr_q,
  output logic [1:0]       sr_c,
  output logic             sr_carry_msb,
  output logic             sr_carry_lsb,
  output logic [3:0]       sr_data_in,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       data_q, data_d;
  logic             ill_q, ill_d;
  logic             cmd_illegal;
  logic             active;

`ifdef SHREG_ROTATE_EN
  assign cmd_illegal = 1'b0;
`else
  assign cmd_illegal = (cmd_op > OP_SHRS);
`endif

  // State and latched command registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      data_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state, count and decoded outputs from registered state
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    ill_d      = ill_q;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    active     = 1'b0;
    sr_data_in = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          op_d   = cmd_op;
          cnt_d  = cmd_cnt;
          data_d = cmd_data;
          ill_d  = cmd_illegal;
          if (cmd_illegal)              state_d = ST_DONE;
          else if (cmd_op == OP_LOAD)   state_d = ST_LOAD;
          else if (cmd_cnt == '0)       state_d = ST_DONE;
          else                          state_d = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        active     = 1'b1;
        sr_data_in = data_q;
        state_d    = ST_DONE;
      end
      ST_SHIFT: begin
        active = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = ill_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  shreg_carry_sel u_carry_sel (
    .op        (op_q),
    .active    (active),
    .sr_q      (sr_q),
    .ser_in    (ser_in),
    .mode      (sr_c),
    .carry_msb (sr_carry_msb),
    .carry_lsb (sr_carry_lsb)
  );

endmodule

// File: tb/tb_shreg_ctrl.sv
// Directed bench for shreg_ctrl with a behavioural shreg closing the sr_q loop.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Rotate cases follow SHREG_ROTATE_EN the same way the RTL does.
module tb_shreg_ctrl;

  logic       clk;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       ser_in;
  logic [3:0] sr_q = 4'b0000;
  logic [1:0] sr_c;
  logic       sr_carry_msb;
  logic       sr_carry_lsb;
  logic [3:0] sr_data_in;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  shreg_ctrl #(.CNT_W(3)) dut (
    .clk          (clk),
    .clr          (clr),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_cnt      (cmd_cnt),
    .cmd_data     (cmd_data),
    .ser_in       (ser_in),
    .sr_q         (sr_q),
    .sr_c         (sr_c),
    .sr_carry_msb (sr_carry_msb),
    .sr_carry_lsb (sr_carry_lsb),
    .sr_data_in   (sr_data_in),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shreg (not reset by clr)
  always @(posedge clk) begin
    case (sr_c)
      2'b01:   sr_q <= {sr_carry_msb, sr_q[3:1]};
      2'b10:   sr_q <= {sr_q[2:0], sr_carry_lsb};
      2'b11:   sr_q <= sr_data_in;
      default: sr_q <= sr_q;
    endcase
  end

  // Count accepted handshakes
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge (accepted there when idle)
  task automatic send(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data);
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load(input logic [3:0] data);
    send(3'b000, 3'd0, data);
    tick();
    tick();
  endtask

  int acc0;

  initial begin
    clr = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_cnt = '0; cmd_data = '0; ser_in = 1'b0;
    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_src", sr_c, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_data", sr_data_in, 0);
    tick();
    clr = 1'b1;
    tick();

    // LOAD 1011
    send(3'b000, 3'd0, 4'b1011);
    chk("ld_src", sr_c, 2'b11);
    chk("ld_din", sr_data_in, 4'b1011);
    chk("ld_busy", busy, 1);
    chk("ld_ready", cmd_ready, 0);
    tick();
    chk("ld_q", sr_q, 4'b1011);
    chk("ld_done", done, 1);
    chk("ld_err", err, 0);
    chk("ld_src_done", sr_c, 0);
    tick();
    chk("ld_done_clr", done, 0);
    chk("ld_ready2", cmd_ready, 1);

    // SHL 2: 1011 -> 0110 -> 1100
    send(3'b001, 3'd2, 4'b0000);
    chk("shl_src", sr_c, 2'b10);
    chk("shl_lsb", sr_carry_lsb, 0);
    tick();
    chk("shl_q1", sr_q, 4'b0110);
    chk("shl_done1", done, 0);
    tick();
    chk("shl_q2", sr_q, 4'b1100);
    chk("shl_done2", done, 1);
    tick();
    chk("shl_done3", done, 0);
    chk("shl_ready", cmd_ready, 1);

    // SHRS 2 with ser_in=1 from 0000: 1000 -> 1100
    load(4'b0000);
    ser_in = 1'b1;
    send(3'b100, 3'd2, 4'b0000);
    chk("shrs_src", sr_c, 2'b01);
    chk("shrs_msb", sr_carry_msb, 1);
    tick();
    chk("shrs_q1", sr_q, 4'b1000);
    chk("shrs_done1", done, 0);
    tick();
    chk("shrs_q2", sr_q, 4'b1100);
    chk("shrs_done2", done, 1);
    tick();
    chk("shrs_done3", done, 0);

    // SHLS 2, ser_in sampled live: 1100 -> 1001 (ser 1) -> 0010 (ser 0)
    ser_in = 1'b1;
    send(3'b011, 3'd2, 4'b0000);
    chk("shls_lsb1", sr_carry_lsb, 1);
    tick();
    chk("shls_q1", sr_q, 4'b1001);
    ser_in = 1'b0;
    #1;
    chk("shls_lsb2", sr_carry_lsb, 0);
    tick();
    chk("shls_q2", sr_q, 4'b0010);
    chk("shls_done", done, 1);
    tick();

`ifdef SHREG_ROTATE_EN
    // ROR 1 from 1011 -> 1101
    load(4'b1011);
    send(3'b110, 3'd1, 4'b0000);
    chk("ror_msb", sr_carry_msb, 1);
    tick();
    chk("ror_q", sr_q, 4'b1101);
    chk("ror_done", done, 1);
    chk("ror_err", err, 0);
    tick();
    // ASR 3 from 1000 -> 1100 -> 1110 -> 1111
    load(4'b1000);
    send(3'b111, 3'd3, 4'b0000);
    tick();
    chk("asr_q1", sr_q, 4'b1100);
    tick();
    chk("asr_q2", sr_q, 4'b1110);
    tick();
    chk("asr_q3", sr_q, 4'b1111);
    chk("asr_done", done, 1);
    tick();
`else
    // ROL illegal: done+err immediately, register untouched
    load(4'b1011);
    send(3'b101, 3'd3, 4'b0000);
    chk("rol_done", done, 1);
    chk("rol_err", err, 1);
    chk("rol_src", sr_c, 0);
    tick();
    chk("rol_q", sr_q, 4'b1011);
    chk("rol_done_clr", done, 0);
    chk("rol_err_clr", err, 0);
    chk("rol_ready", cmd_ready, 1);
`endif

    // SHL cnt 0: done next cycle, no mode drive, sr_q unchanged
    load(4'b0101);
    send(3'b001, 3'd0, 4'b0000);
    chk("z_done", done, 1);
    chk("z_err", err, 0);
    chk("z_src", sr_c, 0);
    tick();
    chk("z_q", sr_q, 4'b0101);
    chk("z_done_clr", done, 0);

    // cmd_valid held across 5 edges: accepts at edges 0 and 3 only
    load(4'b0001);
    acc0 = acc_cnt;
    cmd_op = 3'b001; cmd_cnt = 3'd1; cmd_data = 4'b0000;
    cmd_valid = 1'b1;
    repeat (5) tick();
    cmd_valid = 1'b0;
    chk("hold_acc", acc_cnt - acc0, 2);
    chk("hold_q", sr_q, 4'b0100);
    chk("hold_done", done, 1);
    tick();

    // Reset mid-SHIFT of SHL 5 from 0001
    load(4'b0001);
    send(3'b001, 3'd5, 4'b0000);
    tick();
    tick();
    chk("mid_q", sr_q, 4'b0100);
    chk("mid_busy", busy, 1);
    clr = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_src", sr_c, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_lsb", sr_carry_lsb, 0);
    tick();
    clr = 1'b1;
    tick();
    tick();
    chk("post_q", sr_q, 4'b0100);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
